vga_plot_scheduler: RTL

//  Shares the single-pixel vga_adapter write port (x, y, colour, plot) between

---
 rtl/vga_plot_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/vga_plot_scheduler.sv
// vga_plot_scheduler: round-robin arbiter that lets several box-drawing requesters share the
// single-pixel write port of vga_adapter. The winner's box is swept one pixel per clock in
// raster order, off-screen pixels are suppressed, and a done pulse is returned at the end.
module vga_plot_scheduler #(
   parameter int unsigned NREQ    = 3,
   parameter int unsigned XDIM    = 10,
   parameter int unsigned YDIM    = 10,
   parameter int unsigned XSCREEN = 160,
   parameter int unsigned YSCREEN = 120
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [NREQ-1:0]     req,
   input  logic [8*NREQ-1:0]   req_x,
   input  logic [7*NREQ-1:0]   req_y,
   input  logic [3*NREQ-1:0]   req_colour,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     done,
   output logic                busy,
   output logic [7:0]          vga_x,
   output logic [6:0]          vga_y,
   output logic [2:0]          vga_colour,
   output logic                plot
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned XW = (XDIM > 1) ? $clog2(XDIM) : 1;
   localparam int unsigned YW = (YDIM > 1) ? $clog2(YDIM) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StDraw,
      StDone
   } state_e;

   state_e          state_q;
   logic [IW-1:0]   ptr_q;
   logic [IW-1:0]   win_q;
   logic [7:0]      bx_q;
   logic [6:0]      by_q;
   logic [2:0]      col_q;
   logic [XW-1:0]   xc_q;
   logic [YW-1:0]   yc_q;

   // Arbiter results
   logic            arb_found;
   logic [IW-1:0]   arb_idx;
   logic [NREQ-1:0] arb_onehot;
   logic [7:0]      arb_x;
   logic [6:0]      arb_y;
   logic [2:0]      arb_col;
   int              cand;

   // Raster stepping and next-pixel address
   logic            x_wrap;
   logic            last_pix;
   logic [XW-1:0]   xc_nx;
   logic [YW-1:0]   yc_nx;
   logic [7:0]      pix_bx;
   logic [6:0]      pix_by;
   logic [XW-1:0]   pix_xc;
   logic [YW-1:0]   pix_yc;
   logic [8:0]      sum_x;
   logic [7:0]      sum_y;
   logic            on_screen;

   // Round-robin pick: first requester at or above the pointer, wrapping modulo NREQ.
   always_comb begin
      arb_found  = 1'b0;
      arb_idx    = '0;
      arb_onehot = '0;
      arb_x      = '0;
      arb_y      = '0;
      arb_col    = '0;
      cand       = 0;
      for (int i = 0; i < int'(NREQ); i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= int'(NREQ)) begin
            cand = cand - int'(NREQ);
         end
         if (!arb_found && req[cand]) begin
            arb_found        = 1'b1;
            arb_idx          = IW'(cand);
            arb_onehot[cand] = 1'b1;
            arb_x            = req_x[8*cand +: 8];
            arb_y            = req_y[7*cand +: 7];
            arb_col          = req_colour[3*cand +: 3];
         end
      end
   end

   // Address of the pixel that will be presented after the coming edge, plus its clip test.
   always_comb begin
      x_wrap   = (xc_q == XW'(XDIM - 1));
      last_pix = x_wrap && (yc_q == YW'(YDIM - 1));
      xc_nx    = x_wrap ? '0 : xc_q + 1'b1;
      yc_nx    = x_wrap ? yc_q + 1'b1 : yc_q;
      if (state_q == StIdle) begin
         // First pixel of a new box comes straight from the winning requester.
         pix_bx = arb_x;
         pix_by = arb_y;
         pix_xc = '0;
         pix_yc = '0;
      end else begin
         pix_bx = bx_q;
         pix_by = by_q;
         pix_xc = xc_nx;
         pix_yc = yc_nx;
      end
      // Widened sums so a box hanging off the right/bottom edge is detected, not wrapped.
      sum_x     = {1'b0, pix_bx} + 9'(pix_xc);
      sum_y     = {1'b0, pix_by} + 8'(pix_yc);
      on_screen = (32'(sum_x) < XSCREEN) && (32'(sum_y) < YSCREEN);
   end

   // Control FSM with all outputs registered; xc/yc name the pixel currently on vga_*.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         win_q      <= '0;
         bx_q       <= '0;
         by_q       <= '0;
         col_q      <= '0;
         xc_q       <= '0;
         yc_q       <= '0;
         gnt        <= '0;
         done       <= '0;
         busy       <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         plot       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (arb_found) begin
                  state_q    <= StDraw;
                  gnt        <= arb_onehot;
                  win_q      <= arb_idx;
                  bx_q       <= arb_x;
                  by_q       <= arb_y;
                  col_q      <= arb_col;
                  xc_q       <= '0;
                  yc_q       <= '0;
                  busy       <= 1'b1;
                  vga_x      <= sum_x[7:0];
                  vga_y      <= sum_y[6:0];
                  vga_colour <= arb_col;
                  plot       <= on_screen;
               end
            end
            StDraw: begin
               if (last_pix) begin
                  state_q <= StDone;
                  plot    <= 1'b0;
                  done    <= gnt;
               end else begin
                  xc_q       <= xc_nx;
                  yc_q       <= yc_nx;
                  vga_x      <= sum_x[7:0];
                  vga_y      <= sum_y[6:0];
                  vga_colour <= col_q;
                  plot       <= on_screen;
               end
            end
            StDone: begin
               state_q <= StIdle;
               done    <= '0;
               gnt     <= '0;
               busy    <= 1'b0;
               ptr_q   <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: begin
               state_q <= StIdle;
               gnt     <= '0;
               done    <= '0;
               busy    <= 1'b0;
               plot    <= 1'b0;
            end
         endcase
      end
   end

endmodule
